pkt_buf_sched: RTL and testbench



---
 rtl/pkt_buf_pkg.sv | 31 +++
 rtl/pkt_buf_sched_if.sv | 53 +++++
 rtl/pkt_buf_slot.sv | 69 ++++++
 rtl/pkt_buf_sched.sv | 135 +++++++++++++
 tb/tb_pkt_buf_sched.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/pkt_buf_pkg.sv
//==============================================================================
// pkt_buf_pkg : shared types and constants for the packet buffer scheduler
// Rev 1.0
//==============================================================================
`default_nettype none

package pkt_buf_pkg;

  typedef enum logic [2:0] {
    FREE  = 3'd0,
    FILL  = 3'd1,
    FULL  = 3'd2,
    BUSY  = 3'd3,
    FLUSH = 3'd4
  } buf_state_e;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_FILL = 1'b1
  } wr_state_e;

  localparam int FLUSH_CYCLES = 2;
  localparam int PTR_W        = 2;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p, input int n);
    return (int'(p) == n - 1) ? '0 : p + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pkt_buf_sched_if.sv
//==============================================================================
// pkt_buf_sched_if : upstream stream, buffer-pool and consumer signals
// Rev 1.0
//==============================================================================
`default_nettype none

interface pkt_buf_sched_if #(
  parameter int NUM_BUF = 2,
  parameter int LEN_W   = 11
);
  logic [31:0]              s_axis_tdata;
  logic [3:0]               s_axis_tkeep;
  logic                     s_axis_tlast;
  logic                     s_axis_tvalid;
  logic                     s_axis_tready;
  logic [31:0]              b_axis_tdata;
  logic [3:0]               b_axis_tkeep;
  logic                     b_axis_tlast;
  logic [NUM_BUF-1:0]       b_axis_tvalid;
  logic [NUM_BUF-1:0]       b_axis_tready;
  logic [NUM_BUF-1:0]       buf_ready;
  logic [NUM_BUF*LEN_W-1:0] buf_len;
  logic [NUM_BUF-1:0]       buf_flush;
  logic                     pkt_valid;
  logic [1:0]               pkt_sel;
  logic [LEN_W-1:0]         pkt_len;
  logic                     pkt_ack;
  logic                     pkt_done;
  logic                     timeout_err;
  logic [15:0]              err_cnt;

  modport master (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
    output s_axis_tready,
    output b_axis_tdata, b_axis_tkeep, b_axis_tlast, b_axis_tvalid,
    input  b_axis_tready, buf_ready, buf_len,
    output buf_flush, pkt_valid, pkt_sel, pkt_len,
    input  pkt_ack, pkt_done,
    output timeout_err, err_cnt
  );

  modport slave (
    output s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
    input  s_axis_tready,
    input  b_axis_tdata, b_axis_tkeep, b_axis_tlast, b_axis_tvalid,
    output b_axis_tready, buf_ready, buf_len,
    input  buf_flush, pkt_valid, pkt_sel, pkt_len,
    output pkt_ack, pkt_done,
    input  timeout_err, err_cnt
  );
endinterface

`default_nettype wire

// File: rtl/pkt_buf_slot.sv
//==============================================================================
// pkt_buf_slot : lifecycle state, flush timing and watchdog of one buffer
// Rev 1.0
//==============================================================================
`default_nettype none

module pkt_buf_slot
  import pkt_buf_pkg::*;
#(
  parameter int TIMEOUT = 4096
) (
  input  wire        aclk,
  input  wire        areset,
  input  wire        alloc,
  input  wire        fill_done,
  input  wire        take,
  input  wire        done,
  output buf_state_e state,
  output logic       flush,
  output logic       timeout
);
  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int FC_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;

  buf_state_e      state_nxt;
  logic [WD_W-1:0] wdog;
  logic [FC_W-1:0] fcnt;
  logic            wd_expire;
  logic            flush_nxt;

  // A done in the expiry cycle wins, so the watchdog only fires without it
  assign wd_expire = (state == BUSY) && !done && (wdog == WD_W'(TIMEOUT - 1));

  always_ff @(posedge aclk) begin
    if (areset) begin
      state   <= FREE;
      wdog    <= '0;
      fcnt    <= '0;
      flush   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      wdog    <= (state == BUSY) ? wdog + 1'b1 : '0;
      fcnt    <= (state == FLUSH) ? fcnt + 1'b1 : '0;
      flush   <= flush_nxt;
      timeout <= wd_expire;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FREE:    if (alloc)              state_nxt = FILL;
      FILL:    if (fill_done)          state_nxt = FULL;
      FULL:    if (take)               state_nxt = BUSY;
      BUSY:    if (done || wd_expire)  state_nxt = FLUSH;
      FLUSH:   if (fcnt == FC_W'(FLUSH_CYCLES - 1)) state_nxt = FREE;
      default:                         state_nxt = FREE;
    endcase
  end

  // Flush pulses only in the first FLUSH cycle so the buffer's edge detector re-arms
  always_comb begin
    flush_nxt = (state_nxt == FLUSH) && (state != FLUSH);
  end

endmodule

`default_nettype wire

// File: rtl/pkt_buf_sched.sv
//==============================================================================
// pkt_buf_sched : steers packets into a buffer pool and offers them in order
// Rev 1.0
//==============================================================================
`default_nettype none

module pkt_buf_sched
  import pkt_buf_pkg::*;
#(
  parameter int NUM_BUF = 2,
  parameter int LEN_W   = 11,
  parameter int TIMEOUT = 4096
) (
  input wire               aclk,
  input wire               areset,
  pkt_buf_sched_if.master  bus
);
  wr_state_e          wr_state, wr_state_nxt;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  buf_state_e         slot_state [NUM_BUF];
  logic [NUM_BUF-1:0] alloc, fill_done, take, slot_flush, slot_timeout, is_busy;
  logic               wr_free, wr_tready, filling, beat_end;
  logic               rd_full, rd_ready, any_busy, take_any, valid_nxt;
  logic [LEN_W-1:0]   rd_len;
  logic               pkt_valid_q;
  logic [1:0]         pkt_sel_q;
  logic [LEN_W-1:0]   pkt_len_q;
  logic [15:0]        err_cnt_q;

  always_comb begin
    wr_free   = 1'b0;
    wr_tready = 1'b0;
    rd_full   = 1'b0;
    rd_ready  = 1'b0;
    rd_len    = '0;
    for (int i = 0; i < NUM_BUF; i++) begin
      if (wr_ptr == PTR_W'(i)) begin
        wr_free   = (slot_state[i] == FREE);
        wr_tready = bus.b_axis_tready[i];
      end
      if (rd_ptr == PTR_W'(i)) begin
        rd_full  = (slot_state[i] == FULL);
        rd_ready = bus.buf_ready[i];
        rd_len   = bus.buf_len[i*LEN_W +: LEN_W];
      end
    end
  end

  assign filling  = (wr_state == W_FILL);
  assign beat_end = filling && bus.s_axis_tvalid && wr_tready &&
                    (bus.s_axis_tlast || bus.s_axis_tkeep != 4'hF);
  assign any_busy = |is_busy;
  assign take_any = pkt_valid_q && bus.pkt_ack && !any_busy && rd_full;
  assign valid_nxt = rd_full && rd_ready && !any_busy && !take_any;

  always_ff @(posedge aclk) begin
    if (areset) wr_state <= W_IDLE;
    else        wr_state <= wr_state_nxt;
  end

  always_comb begin
    wr_state_nxt = wr_state;
    case (wr_state)
      W_IDLE:  if (wr_free)  wr_state_nxt = W_FILL;
      W_FILL:  if (beat_end) wr_state_nxt = W_IDLE;
      default:               wr_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    bus.s_axis_tready = filling && wr_tready;
    alloc     = '0;
    fill_done = '0;
    take      = '0;
    bus.b_axis_tvalid = '0;
    for (int i = 0; i < NUM_BUF; i++) begin
      if (wr_ptr == PTR_W'(i)) begin
        alloc[i]             = (wr_state == W_IDLE) && wr_free;
        fill_done[i]         = beat_end;
        bus.b_axis_tvalid[i] = filling && bus.s_axis_tvalid;
      end
      if (rd_ptr == PTR_W'(i)) take[i] = take_any;
    end
  end

  // Data lanes are quiet whenever no buffer is being filled
  assign bus.b_axis_tdata = filling ? bus.s_axis_tdata : '0;
  assign bus.b_axis_tkeep = filling ? bus.s_axis_tkeep : '0;
  assign bus.b_axis_tlast = filling && bus.s_axis_tlast;

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pkt_valid_q <= 1'b0;
      pkt_sel_q   <= '0;
      pkt_len_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (beat_end) wr_ptr <= ptr_inc(wr_ptr, NUM_BUF);
      if (take_any) rd_ptr <= ptr_inc(rd_ptr, NUM_BUF);
      pkt_valid_q <= valid_nxt;
      pkt_sel_q   <= rd_ptr;
      pkt_len_q   <= rd_len;
      if (|slot_timeout && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign bus.pkt_valid   = pkt_valid_q;
  assign bus.pkt_sel     = pkt_sel_q;
  assign bus.pkt_len     = pkt_len_q;
  assign bus.err_cnt     = err_cnt_q;
  assign bus.buf_flush   = slot_flush;
  assign bus.timeout_err = |slot_timeout;

  generate
    for (genvar i = 0; i < NUM_BUF; i++) begin : g_slot
      assign is_busy[i] = (slot_state[i] == BUSY);
      pkt_buf_slot #(.TIMEOUT(TIMEOUT)) u_slot (
        .aclk      (aclk),
        .areset    (areset),
        .alloc     (alloc[i]),
        .fill_done (fill_done[i]),
        .take      (take[i]),
        .done      (bus.pkt_done),
        .state     (slot_state[i]),
        .flush     (slot_flush[i]),
        .timeout   (slot_timeout[i])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_pkt_buf_sched.sv
//==============================================================================
// tb_pkt_buf_sched : directed self-checking bench for pkt_buf_sched
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_pkt_buf_sched;
  localparam int NB = 2;
  localparam int LW = 11;
  localparam int TO = 16;

  logic aclk   = 1'b0;
  logic areset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 aclk = ~aclk;

  pkt_buf_sched_if #(.NUM_BUF(NB), .LEN_W(LW)) bus ();

  pkt_buf_sched #(.NUM_BUF(NB), .LEN_W(LW), .TIMEOUT(TO)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset;
    bus.s_axis_tvalid = 1'b0;
    bus.pkt_ack       = 1'b0;
    bus.pkt_done      = 1'b0;
    bus.buf_ready     = '0;
    areset = 1'b1;
    step();
    step();
    areset = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l, input int eb);
    bit sent = 0;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = d;
    bus.s_axis_tkeep  = k;
    bus.s_axis_tlast  = l;
    for (int i = 0; i < 40 && !sent; i++) begin
      #1;
      if (bus.s_axis_tready) begin
        check("beat_tvalid", 32'(bus.b_axis_tvalid), 32'(1 << eb));
        check("beat_tdata", bus.b_axis_tdata, d);
        sent = 1;
      end
      @(posedge aclk);
      #1;
    end
    if (!sent) check("beat_wait", 32'd0, 32'd1);
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
  endtask

  task automatic send_pkt(input int n, input logic [3:0] lk, input int eb, input logic [31:0] base);
    for (int b = 0; b < n; b++)
      send_beat(base + 32'(b), (b == n - 1) ? lk : 4'hF, (b == n - 1), eb);
  endtask

  task automatic wait_valid(input int sel, input int len);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.pkt_valid) seen = 1;
      else step();
    end
    check("pkt_valid", 32'(seen), 32'd1);
    check("pkt_sel", 32'(bus.pkt_sel), 32'(sel));
    check("pkt_len", 32'(bus.pkt_len), 32'(len));
  endtask

  task automatic ack_pkt;
    bus.pkt_ack = 1'b1;
    step();
    bus.pkt_ack = 1'b0;
  endtask

  task automatic pulse_done;
    bus.pkt_done = 1'b1;
    step();
    bus.pkt_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    bus.s_axis_tdata  = '0;
    bus.s_axis_tkeep  = 4'hF;
    bus.s_axis_tlast  = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    bus.b_axis_tready = '1;
    bus.buf_ready     = '0;
    bus.buf_len       = '0;
    bus.pkt_ack       = 1'b0;
    bus.pkt_done      = 1'b0;

    // Reset state
    do_reset();
    check("rst_pkt_valid", 32'(bus.pkt_valid), 32'd0);
    check("rst_pkt_len", 32'(bus.pkt_len), 32'd0);
    check("rst_flush", 32'(bus.buf_flush), 32'd0);
    check("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    check("rst_tready", 32'(bus.s_axis_tready), 32'd0);
    check("rst_tvalid", 32'(bus.b_axis_tvalid), 32'd0);

    // Single packet, ack, done, flush timing
    send_pkt(3, 4'h3, 0, 32'hA000_0000);
    bus.buf_ready = 2'b01;
    bus.buf_len   = {11'd0, 11'd10};
    wait_valid(0, 10);
    ack_pkt();
    check("busy_valid_low", 32'(bus.pkt_valid), 32'd0);
    step();
    pulse_done();
    check("done_flush_hi", 32'(bus.buf_flush), 32'b01);
    check("done_no_tmo", 32'(bus.timeout_err), 32'd0);
    step();
    check("done_flush_lo", 32'(bus.buf_flush), 32'b00);
    bus.buf_ready = 2'b00;

    // Arrival order with both buffers full
    do_reset();
    send_pkt(2, 4'hF, 0, 32'hB000_0000);
    send_pkt(4, 4'h1, 1, 32'hC000_0000);
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = 32'hD000_0000;
    bus.s_axis_tlast  = 1'b1;
    repeat (3) step();
    check("full_tready", 32'(bus.s_axis_tready), 32'd0);
    check("full_tvalid", 32'(bus.b_axis_tvalid), 32'd0);
    bus.s_axis_tvalid = 1'b0;
    bus.buf_ready = 2'b11;
    bus.buf_len   = {11'd13, 11'd8};
    wait_valid(0, 8);
    ack_pkt();
    pulse_done();
    bus.buf_ready = 2'b10;
    send_pkt(1, 4'hF, 0, 32'hE000_0000);
    bus.buf_ready = 2'b11;
    bus.buf_len   = {11'd13, 11'd4};
    wait_valid(1, 13);
    ack_pkt();
    pulse_done();
    bus.buf_ready = 2'b01;
    wait_valid(0, 4);
    ack_pkt();
    pulse_done();
    bus.buf_ready = 2'b00;

    // Watchdog reclaim
    do_reset();
    send_pkt(1, 4'hF, 0, 32'h1000_0000);
    bus.buf_ready = 2'b01;
    bus.buf_len   = {11'd0, 11'd5};
    wait_valid(0, 5);
    ack_pkt();
    repeat (15) step();
    check("wd_early", 32'(bus.timeout_err), 32'd0);
    step();
    check("wd_tmo", 32'(bus.timeout_err), 32'd1);
    check("wd_flush", 32'(bus.buf_flush), 32'b01);
    step();
    check("wd_tmo_pulse", 32'(bus.timeout_err), 32'd0);
    check("wd_err_cnt", 32'(bus.err_cnt), 32'd1);
    bus.buf_ready = 2'b00;
    send_pkt(1, 4'hF, 1, 32'h2000_0000);
    send_pkt(1, 4'hF, 0, 32'h3000_0000);

    // Done collides with watchdog expiry
    bus.buf_ready = 2'b11;
    bus.buf_len   = {11'd7, 11'd9};
    wait_valid(1, 7);
    ack_pkt();
    repeat (15) step();
    bus.pkt_done = 1'b1;
    step();
    bus.pkt_done = 1'b0;
    check("col_no_tmo", 32'(bus.timeout_err), 32'd0);
    check("col_flush", 32'(bus.buf_flush), 32'b10);
    step();
    check("col_err_cnt", 32'(bus.err_cnt), 32'd1);
    bus.buf_ready = 2'b01;
    wait_valid(0, 9);

    // Reset in the middle of a fill
    send_beat(32'hF000_0000, 4'hF, 1'b0, 1);
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = 32'hF000_0001;
    areset = 1'b1;
    bus.buf_ready = 2'b00;
    step();
    check("mid_rst_valid", 32'(bus.pkt_valid), 32'd0);
    check("mid_rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    check("mid_rst_flush", 32'(bus.buf_flush), 32'd0);
    check("mid_rst_tready", 32'(bus.s_axis_tready), 32'd0);
    check("mid_rst_tvalid", 32'(bus.b_axis_tvalid), 32'd0);
    areset = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    send_pkt(2, 4'h7, 0, 32'h4000_0000);
    bus.buf_ready = 2'b01;
    bus.buf_len   = {11'd15, 11'd6};
    wait_valid(0, 6);
    ack_pkt();
    pulse_done();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
